// File: rtl/arithmetic_encoder.sv
// ---------------------------------------------------------------------------
// arithmetic_encoder
//
// Multi-symbol range encoder datapath, equivalent to the AV1 od_ec_encode_q15
// range/low update. On each enabled rising edge it takes one symbol's
// inverse-CDF bounds (fl, fh) and performs these steps:
//   * It splits the current range.
//   * It accumulates the skipped interval into low.
//   * It renormalises both values so the range MSB is set again.
// Byte emission and carry propagation belong to the downstream flusher.
//
// Optional build macro: ARITH_ENC_VALID_EN
//   When defined, the general_valid input exists, and state advances only on
//   edges where it is high. When undefined, a symbol is encoded on every edge
//   that is not a reset edge.
//
// Ports:
//   general_clk    in   1            rising-edge clock
//   reset          in   1            synchronous active-high reset
//   general_valid  in   1            (ARITH_ENC_VALID_EN only) encode enable
//   general_fl     in   RANGE_WIDTH  inverse CDF of symbol-1 (32768 = sym 0)
//   general_fh     in   RANGE_WIDTH  inverse CDF of symbol
//   general_symbol in   SYMBOL_WIDTH symbol index s
//   general_nsyms  in   SYMBOL_WIDTH+1 alphabet size
//   RANGE_OUTPUT   out  RANGE_WIDTH  registered range state
//   LOW_OUTPUT     out  LOW_WIDTH    registered low state
// ---------------------------------------------------------------------------
module arithmetic_encoder #(
    parameter int GENERAL_RANGE_WIDTH    = 16,
    parameter int GENERAL_LOW_WIDTH      = 24,
    parameter int GENERAL_SYMBOL_WIDTH   = 4,
    parameter int GENERAL_LUT_ADDR_WIDTH = 8,
    parameter int GENERAL_LUT_DATA_WIDTH = 16,
    parameter int GENERAL_D_SIZE         = 4
) (
    input  logic                              general_clk,
    input  logic                              reset,
`ifdef ARITH_ENC_VALID_EN
    input  logic                              general_valid,
`endif
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fl,
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fh,
    input  logic [GENERAL_SYMBOL_WIDTH-1:0]   general_symbol,
    input  logic [GENERAL_SYMBOL_WIDTH:0]     general_nsyms,
    output logic [GENERAL_RANGE_WIDTH-1:0]    RANGE_OUTPUT,
    output logic [GENERAL_LOW_WIDTH-1:0]      LOW_OUTPUT
);

    // Width of the unsigned intermediate arithmetic: 8-bit x 10-bit products.
    localparam int PW = 18;

    localparam logic [GENERAL_RANGE_WIDTH-1:0] RANGE_RESET = 16'd32768;
    localparam logic [GENERAL_RANGE_WIDTH-1:0] FL_SYM0     = 16'd32768;
    localparam logic [PW-1:0]                  EC_MIN_PROB = 18'd4;

    // Leading-zero ROM for an 8-bit address. The priority casez is the
    // compact form of the 256-entry table. Address 0 maps to 8. Only the low
    // GENERAL_D_SIZE bits of each entry carry information.
    function automatic logic [GENERAL_LUT_DATA_WIDTH-1:0] lz_rom(
        input logic [GENERAL_LUT_ADDR_WIDTH-1:0] addr
    );
        logic [GENERAL_LUT_DATA_WIDTH-1:0] data;
        casez (addr)
            8'b1???????: data = 16'd0;
            8'b01??????: data = 16'd1;
            8'b001?????: data = 16'd2;
            8'b0001????: data = 16'd3;
            8'b00001???: data = 16'd4;
            8'b000001??: data = 16'd5;
            8'b0000001?: data = 16'd6;
            8'b00000001: data = 16'd7;
            8'b00000000: data = 16'd8;
            default:     data = 16'd0;
        endcase
        return data;
    endfunction

    logic [GENERAL_RANGE_WIDTH-1:0]    range_q, range_d;
    logic [GENERAL_LOW_WIDTH-1:0]      low_q,   low_d;

    logic [7:0]                        r_hi_s;
    logic [9:0]                        fl_hi_s;
    logic [9:0]                        fh_hi_s;
    logic [PW-1:0]                     prod_l_s;
    logic [PW-1:0]                     prod_h_s;
    logic [PW-1:0]                     n_s;
    logic [PW-1:0]                     sym_s;
    logic [PW-1:0]                     u_s;
    logic [PW-1:0]                     v_s;
    logic [GENERAL_RANGE_WIDTH-1:0]    r_prime_s;
    logic [GENERAL_LOW_WIDTH-1:0]      l_prime_s;
    logic [GENERAL_LUT_DATA_WIDTH-1:0] lz_hi_s;
    logic [GENERAL_LUT_DATA_WIDTH-1:0] lz_lo_s;
    logic [GENERAL_D_SIZE-1:0]         d_s;
    logic [GENERAL_RANGE_WIDTH-1:0]    enc_range_s;
    logic [GENERAL_LOW_WIDTH-1:0]      enc_low_s;
    logic                              enc_en_s;

`ifdef ARITH_ENC_VALID_EN
    assign enc_en_s = general_valid;
`else
    assign enc_en_s = 1'b1;
`endif

    // Interval split: compute u and v from the current range and the CDF bounds.
    always_comb begin
        r_hi_s   = 8'(range_q >> 8);
        fl_hi_s  = 10'(general_fl >> 6);
        fh_hi_s  = 10'(general_fh >> 6);
        prod_l_s = PW'(r_hi_s) * PW'(fl_hi_s);
        prod_h_s = PW'(r_hi_s) * PW'(fh_hi_s);
        n_s      = PW'(general_nsyms) - 18'd1;
        sym_s    = PW'(general_symbol);
        // N-(s-1) is written as N-s+1 so s=0 never underflows before the add.
        u_s      = (prod_l_s >> 1) + EC_MIN_PROB * (n_s - sym_s + 18'd1);
        v_s      = (prod_h_s >> 1) + EC_MIN_PROB * (n_s - sym_s);
    end

    // Range/low update before normalisation. Symbol 0 keeps low and takes the top slice.
    always_comb begin
        if (general_fl < FL_SYM0) begin
            l_prime_s = low_q + GENERAL_LOW_WIDTH'(PW'(range_q) - u_s);
            r_prime_s = GENERAL_RANGE_WIDTH'(u_s - v_s);
        end else begin
            l_prime_s = low_q;
            r_prime_s = GENERAL_RANGE_WIDTH'(PW'(range_q) - v_s);
        end
    end

    // Normalisation shift: the leading-zero count of r' comes from the ROM, upper byte first.
    always_comb begin
        lz_hi_s = lz_rom(r_prime_s[15:8]);
        lz_lo_s = lz_rom(r_prime_s[7:0]);
        if (r_prime_s == 16'd0) begin
            d_s = 4'd0;
        end else if (r_prime_s[15:8] != 8'd0) begin
            d_s = GENERAL_D_SIZE'(lz_hi_s);
        end else begin
            d_s = 4'd8 + GENERAL_D_SIZE'(lz_lo_s);
        end
        // Bits shifted past the register widths are intentionally discarded.
        enc_range_s = r_prime_s << d_s;
        enc_low_s   = l_prime_s << d_s;
    end

    // Next-state select: encode when enabled, otherwise hold.
    always_comb begin
        if (enc_en_s) begin
            range_d = enc_range_s;
            low_d   = enc_low_s;
        end else begin
            range_d = range_q;
            low_d   = low_q;
        end
    end

    // State registers. Synchronous reset has priority over encoding.
    always_ff @(posedge general_clk) begin
        if (reset) begin
            range_q <= RANGE_RESET;
            low_q   <= 24'd0;
        end else begin
            range_q <= range_d;
            low_q   <= low_d;
        end
    end

    assign RANGE_OUTPUT = range_q;
    assign LOW_OUTPUT   = low_q;

endmodule

// File: tb/tb_arithmetic_encoder.sv
// ---------------------------------------------------------------------------
// tb_arithmetic_encoder
//
// Directed bench for arithmetic_encoder. It applies the following stimulus:
//   * reset values
//   * three hand-computed constant-symbol steps
//   * the symbol-0 path
//   * a mid-stream reset
//   * long streams, where low wraps, checked against a small behavioural model
// When ARITH_ENC_VALID_EN is defined, it also checks the valid-hold behaviour.
// ---------------------------------------------------------------------------
module tb_arithmetic_encoder;

    logic        general_clk = 1'b0;
    logic        reset;
`ifdef ARITH_ENC_VALID_EN
    logic        general_valid;
`endif
    logic [15:0] general_fl;
    logic [15:0] general_fh;
    logic [3:0]  general_symbol;
    logic [4:0]  general_nsyms;
    logic [15:0] RANGE_OUTPUT;
    logic [23:0] LOW_OUTPUT;

    int passed = 0;
    int total  = 0;
    int m_r;
    int m_l;

    arithmetic_encoder dut (
        .general_clk    (general_clk),
        .reset          (reset),
`ifdef ARITH_ENC_VALID_EN
        .general_valid  (general_valid),
`endif
        .general_fl     (general_fl),
        .general_fh     (general_fh),
        .general_symbol (general_symbol),
        .general_nsyms  (general_nsyms),
        .RANGE_OUTPUT   (RANGE_OUTPUT),
        .LOW_OUTPUT     (LOW_OUTPUT)
    );

    always #5 general_clk = ~general_clk;

    task automatic step();
        @(posedge general_clk);
        #1;
    endtask

    task automatic check(input string tag, input int er, input int el);
        total++;
        assert (RANGE_OUTPUT === 16'(er)) passed++;
        else $error("FAIL %s range observed=%0d expected=%0d", tag, RANGE_OUTPUT, er);
        total++;
        assert (LOW_OUTPUT === 24'(el)) passed++;
        else $error("FAIL %s low observed=%0d expected=%0d", tag, LOW_OUTPUT, el);
    endtask

    task automatic check_range_min(input string tag);
        total++;
        assert (RANGE_OUTPUT >= 16'd32768) passed++;
        else $error("FAIL %s range_min observed=%0d expected>=32768", tag, RANGE_OUTPUT);
    endtask

    // Behavioural reference. It normalises by doubling until the range MSB is set.
    function automatic void model(input int r, input int l, input int fl, input int fh,
                                  input int s, input int ns, output int rn, output int ln);
        int n, u, v, rp, lp, guard;
        n = ns - 1;
        if (fl < 32768) begin
            u  = (((r >> 8) * (fl >> 6)) >> 1) + 4 * (n - (s - 1));
            v  = (((r >> 8) * (fh >> 6)) >> 1) + 4 * (n - s);
            lp = (l + (r - u)) & 32'h00FF_FFFF;
            rp = u - v;
        end else begin
            v  = (((r >> 8) * (fh >> 6)) >> 1) + 4 * (n - s);
            lp = l;
            rp = r - v;
        end
        guard = 0;
        while (rp != 0 && rp < 32768 && guard < 16) begin
            rp = rp << 1;
            lp = (lp << 1) & 32'h00FF_FFFF;
            guard++;
        end
        rn = rp & 32'h0000_FFFF;
        ln = lp;
    endfunction

    task automatic drive(input int fl, input int fh, input int s, input int ns);
        general_fl     = 16'(fl);
        general_fh     = 16'(fh);
        general_symbol = 4'(s);
        general_nsyms  = 5'(ns);
    endtask

    // Inverse CDF for a 4-symbol alphabet. Entry 0 is the symbol-0 marker.
    int icdf [5] = '{32768, 24000, 12000, 4000, 0};
    int seq  [10] = '{1, 3, 0, 2, 2, 3, 1, 0, 3, 1};

    initial begin
        reset = 1'b1;
`ifdef ARITH_ENC_VALID_EN
        general_valid = 1'b1;
`endif
        drive(9690, 3202, 3, 10);

        // Reset held for two edges.
        step();
        step();
        check("reset", 32768, 0);

        // Constant symbol: three hand-computed steps.
        reset = 1'b0;
        step();
        check("const_1", 51744, 184608);
        step();
        check("const_2", 40820, 884292);
        step();
        check("const_3", 64264, 7304640);

        // Reset after three symbols discards state on that edge.
        reset = 1'b1;
        step();
        check("mid_reset", 32768, 0);

        // Symbol-0 path starting from reset state.
        reset = 1'b0;
        drive(32768, 16384, 0, 2);
        step();
        check("sym0", 65520, 0);

        // Long constant stream: low wraps past 24 bits.
        reset = 1'b1;
        drive(9690, 3202, 3, 10);
        step();
        reset = 1'b0;
        m_r = 32768;
        m_l = 0;
        for (int i = 0; i < 14; i++) begin
            model(m_r, m_l, 9690, 3202, 3, 10, m_r, m_l);
            step();
            check($sformatf("stream_%0d", i), m_r, m_l);
            check_range_min($sformatf("stream_%0d", i));
        end

        // Mixed symbols, including symbol 0 and the last symbol (fh = 0).
        for (int i = 0; i < 10; i++) begin
            drive(icdf[seq[i]], icdf[seq[i] + 1], seq[i], 4);
            model(m_r, m_l, icdf[seq[i]], icdf[seq[i] + 1], seq[i], 4, m_r, m_l);
            step();
            check($sformatf("mixed_%0d", i), m_r, m_l);
            check_range_min($sformatf("mixed_%0d", i));
        end

`ifdef ARITH_ENC_VALID_EN
        // With valid low, the state holds for two edges, then resumes.
        general_valid = 1'b0;
        drive(20000, 12000, 1, 4);
        step();
        check("hold_1", m_r, m_l);
        step();
        check("hold_2", m_r, m_l);
        general_valid = 1'b1;
        model(m_r, m_l, 20000, 12000, 1, 4, m_r, m_l);
        step();
        check("resume", m_r, m_l);
        // Reset still has priority while valid is low.
        general_valid = 1'b0;
        reset = 1'b1;
        step();
        check("reset_no_valid", 32768, 0);
        reset = 1'b0;
        general_valid = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
